// File: rtl/alu_seq_pkg.sv
// alu_sequencer shared definitions: opcodes, FSM states and instruction fields.
// ALU_SEQ_COND_EN (optional) enables conditional execution via instr[0].
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam int OP_HI    = 7;
    localparam int OP_LO    = 5;
    localparam int RD_HI    = 4;
    localparam int RD_LO    = 3;
    localparam int RS_HI    = 2;
    localparam int RS_LO    = 1;
    localparam int COND_BIT = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Instruction fetch handshake between the instruction source and alu_sequencer.
// master = instruction source, slave = sequencer.
interface alu_seq_if;

    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );

endinterface

// File: rtl/alu_seq_regfile.sv
// Register file: two operand read ports, one debug read port, one write port.
// Reads are combinational, so a same-cycle write is seen only on the next cycle.
module alu_seq_regfile #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control: IDLE -> DECODE -> EXECUTE -> WRITEBACK, one cycle each.
// Define ALU_SEQ_COND_EN to make instr[0] gate the commit on zero_flag.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    alu_seq_if.slave          bus,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic              zero_flag,
    output logic              busy,
`ifdef ALU_SEQ_COND_EN
    output logic              skipped,
`endif
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    logic [7:0]        ir;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [2:0]        op;
    logic [DATA_W-1:0] res;
    logic              zres;
    logic              skip;
    logic              ready;

    logic              accept;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign accept = bus.instr_valid && ready;
    assign rd     = ir[RD_HI:RD_LO];
    assign rs     = ir[RS_HI:RS_LO];

`ifndef ALU_SEQ_COND_EN
    logic unused_cond;
    assign unused_cond = ir[COND_BIT];
`endif

    // Preloads own the write port in IDLE, writeback owns it in WB.
    always_comb begin
        we    = 1'b0;
        waddr = ld_addr;
        wdata = ld_data;
        if (state == ST_WB) begin
            we    = !skip;
            waddr = rd;
            wdata = res;
        end else if (state == ST_IDLE) begin
            we    = ld_en;
        end
    end

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .ra_addr  (rd),
        .rb_addr  (rs),
        .dbg_addr (dbg_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ir        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op        <= OP_ADD;
            res       <= '0;
            zres      <= 1'b0;
            skip      <= 1'b0;
            zero_flag <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
`ifdef ALU_SEQ_COND_EN
            skipped   <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ir    <= bus.instr;
                        state <= ST_DECODE;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    op_a  <= ra_data;
                    op_b  <= rb_data;
                    op    <= ir[OP_HI:OP_LO];
`ifdef ALU_SEQ_COND_EN
                    skip  <= ir[COND_BIT] && !zero_flag;
`else
                    skip  <= 1'b0;
`endif
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res     <= alu_result;
                    zres    <= alu_zero;
                    done    <= 1'b1;
`ifdef ALU_SEQ_COND_EN
                    skipped <= skip;
`endif
                    state   <= ST_WB;
                end
                ST_WB: begin
                    if (!skip) begin
                        zero_flag <= zres;
                    end
                    done    <= 1'b0;
`ifdef ALU_SEQ_COND_EN
                    skipped <= 1'b0;
`endif
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = ready;
    assign alu_a           = op_a;
    assign alu_b           = op_b;
    assign alu_op          = op;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a reference model queues expected
// writebacks at accept time; a negedge monitor checks them on each done.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a, alu_b, alu_result, dbg_data;
    logic [2:0] alu_op;
    logic       alu_zero, done, zero_flag, busy;
    logic [1:0] dbg_addr, main_addr, mon_addr;
    logic       mon_sel = 1'b0;
`ifdef ALU_SEQ_COND_EN
    logic       skipped;
`endif

    always #5 clk = ~clk;

    alu_seq_if bus ();

    assign dbg_addr = mon_sel ? mon_addr : main_addr;

    alu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .done       (done),
        .zero_flag  (zero_flag),
        .busy       (busy),
`ifdef ALU_SEQ_COND_EN
        .skipped    (skipped),
`endif
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Combinational ALU the sequencer drives.
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = ~alu_a;
            3'b110: alu_result = alu_a << 1;
            default: alu_result = alu_a >> 1;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    typedef struct {
        int rd;
        int val;
        int z;
        int skip;
        int a;
        int b;
        int op;
        int dcyc;
    } exp_t;

    exp_t sbq[$];
    int   rf_m[4];
    int   zf_m = 0;
    int   cnt_m = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    int   p_rd, p_val, p_z, p_skip;
    int   errors = 0;
    int   checks = 0;
    bit   pend = 1'b0;

    function automatic int ref_alu(int op, int a, int b);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 255 - a;
            6: return (a * 2) % 256;
            default: return a / 2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: instruction takes effect 3 edges after acceptance.
    initial begin
        foreach (rf_m[i]) rf_m[i] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset === 1'b1) begin
                foreach (rf_m[i]) rf_m[i] = 0;
                zf_m  = 0;
                cnt_m = 0;
                sbq.delete();
            end else if (cnt_m > 0) begin
                cnt_m--;
                if (cnt_m == 0 && p_skip == 0) begin
                    rf_m[p_rd] = p_val;
                    zf_m       = p_z;
                end
            end else begin
                if (ld_en) rf_m[ld_addr] = ld_data;
                if (bus.instr_valid) begin
                    logic [7:0] ins;
                    int op, rd, rs, a, b, v, sk;
                    exp_t e;
                    ins = bus.instr;
                    op  = ins[7:5];
                    rd  = ins[4:3];
                    rs  = ins[2:1];
                    a   = rf_m[rd];
                    b   = rf_m[rs];
                    v   = ref_alu(op, a, b);
`ifdef ALU_SEQ_COND_EN
                    sk  = (ins[0] && zf_m == 0) ? 1 : 0;
`else
                    sk  = 0;
`endif
                    p_rd   = rd;
                    p_val  = v;
                    p_z    = (v == 0) ? 1 : 0;
                    p_skip = sk;
                    cnt_m  = 3;
                    acc_cnt++;
                    e.rd   = rd;
                    e.val  = sk ? a : v;
                    e.z    = sk ? zf_m : p_z;
                    e.skip = sk;
                    e.a    = a;
                    e.b    = b;
                    e.op   = op;
                    e.dcyc = cyc + 2;
                    sbq.push_back(e);
                end
            end
        end
    end

    // Monitor: handshake shape every cycle, writeback contents on done.
    initial begin
        exp_t pe;
        mon_addr = 2'd0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (pend) begin
                    chk("wb_data", {24'd0, dbg_data}, pe.val);
                    chk("wb_zflag", {31'd0, zero_flag}, pe.z);
                    pend    = 1'b0;
                    mon_sel = 1'b0;
                end
                chk("ready", {31'd0, bus.instr_ready}, (cnt_m == 0) ? 1 : 0);
                chk("busy", {31'd0, busy}, (cnt_m != 0) ? 1 : 0);
                if (done === 1'b1) begin
                    done_cnt++;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no pulse");
                    end else begin
                        pe = sbq.pop_front();
                        chk("done_cycle", cyc, pe.dcyc);
                        chk("alu_a", {24'd0, alu_a}, pe.a);
                        chk("alu_b", {24'd0, alu_b}, pe.b);
                        chk("alu_op", {29'd0, alu_op}, pe.op);
`ifdef ALU_SEQ_COND_EN
                        chk("skipped", {31'd0, skipped}, pe.skip);
`endif
                        mon_addr = pe.rd[1:0];
                        mon_sel  = 1'b1;
                        pend     = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || cnt_m != 0 || pend) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic ld(input int a, input int d);
        wait_idle();
        ld_en   = 1'b1;
        ld_addr = a[1:0];
        ld_data = d[7:0];
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic issue(input logic [7:0] ins);
        wait_idle();
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic check_regs(input string name);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            main_addr = i[1:0];
            #1;
            chk(name, {24'd0, dbg_data}, rf_m[i]);
        end
    endtask

    task automatic check_idle_state(input string name);
        chk({name, "_done"}, {31'd0, done}, 0);
        chk({name, "_busy"}, {31'd0, busy}, 0);
        chk({name, "_ready"}, {31'd0, bus.instr_ready}, 1);
        chk({name, "_zflag"}, {31'd0, zero_flag}, 0);
        for (int i = 0; i < 4; i++) begin
            main_addr = i[1:0];
            #1;
            chk({name, "_reg"}, {24'd0, dbg_data}, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int a0, d0;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 8'h00;
        ld_en           = 1'b0;
        ld_addr         = 2'd0;
        ld_data         = 8'h00;
        main_addr       = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle_state("reset");
        chk("reset_alu_a", {24'd0, alu_a}, 0);
        chk("reset_alu_b", {24'd0, alu_b}, 0);
        chk("reset_alu_op", {29'd0, alu_op}, 0);

        ld(0, 10);
        ld(1, 5);
        issue(8'b000_00_01_0);
        check_regs("add");

        ld(0, 10);
        issue(8'b001_00_00_0);
        issue(8'b101_00_00_0);
        check_regs("sub_not");

        ld(2, 8'h81);
        issue(8'b110_10_10_0);
        issue(8'b111_10_10_0);
        ld(0, 8'hFF);
        ld(1, 8'h01);
        issue(8'b000_00_01_0);
        check_regs("shift_wrap");

        // Valid held across three instructions; preload attempted while busy.
        wait_idle();
        d0 = done_cnt;
        a0 = acc_cnt;
        ld(3, 3);
        bus.instr_valid = 1'b1;
        bus.instr       = 8'b000_11_01_0;
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 2'd1;
        ld_data = 8'h77;
        @(negedge clk);
        ld_en   = 1'b0;
        for (int n = 0; n < 40 && acc_cnt < a0 + 3; n++) @(negedge clk);
        bus.instr_valid = 1'b0;
        wait_idle();
        chk("held_pulses", done_cnt - d0, 3);
        check_regs("held");

        // Reset while the ADD is in EXECUTE.
        ld(0, 10);
        ld(1, 5);
        d0 = done_cnt;
        issue(8'b000_00_01_0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_state("midreset");
        repeat (4) @(negedge clk);
        chk("midreset_pulses", done_cnt - d0, 0);

`ifdef ALU_SEQ_COND_EN
        do_reset();
        ld(0, 10);
        ld(1, 5);
        issue(8'b000_00_01_1);
        check_regs("cond_skip");
        ld(2, 7);
        issue(8'b001_10_10_0);
        issue(8'b000_00_01_1);
        check_regs("cond_commit");
`endif

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(2) == 0) ld($urandom_range(3), $urandom_range(255));
            issue(8'($urandom_range(255)));
        end
        check_regs("random");
        chk("queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
